// File: rtl/alu_pkg.sv
// Shared definitions for the ALU logic group.
//   alu_flags_t : condition flags that travel with a logic-unit result
//   ALU_W       : default datapath width of the logic units
package alu_pkg;

  localparam int ALU_W = 64;

  typedef struct packed {
    logic zero;
    logic neg;
  } alu_flags_t;

endpackage : alu_pkg

// File: rtl/and_bitwise.sv
// Purely combinational bitwise AND: y = a & b.
// Each result bit depends only on the same bit of each operand, so there is
// no carry chain. Every bit gets its own gate, which synthesis maps 1:1.
// Ports:
//   a, b : N-bit operands
//   y    : N-bit result
module and_bitwise #(
  parameter int N = 64
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] y
);

  genvar i;
  generate
    for (i = 0; i < N; i++) begin : g_bit
      assign y[i] = a[i] & b[i];
    end
  endgenerate

endmodule : and_bitwise

// File: rtl/alu_and.sv
// Bitwise-AND execution unit of the ALU logic group.
// Operands are sampled on a rising clock edge when in_valid is high. The result
// and its flags appear one cycle later, together with out_valid. There is no
// backpressure; each accepted op overwrites the previous one.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset (release synchronised upstream)
//   in_valid  : a/b valid; the op is accepted at the clock edge
//   a, b      : N-bit operands (narrower callers zero-extend)
//   out_valid : result/flags valid this cycle
//   result    : registered a & b
//   zero      : result == 0
//   neg       : result[N-1]
module alu_and
  import alu_pkg::*;
#(
  parameter int N = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  output logic [N-1:0] result,
  output logic         zero,
  output logic         neg
);

  // Flags are computed from the AND value that is about to be registered.
  // They are stored alongside the result, so the two can never disagree.
  // neg = y[N-1] is the same as a[N-1] & b[N-1].
  function automatic alu_flags_t flags_of(input logic [N-1:0] v);
    alu_flags_t f;
    f.zero = ~|v;
    f.neg  = v[N-1];
    return f;
  endfunction

  logic [N-1:0] and_y_p0;
  alu_flags_t   flags_p0;

  logic [N-1:0] result_p1;
  alu_flags_t   flags_p1;
  logic         vld_p1;

  // ---- stage p0: combinational AND and flag reduction ----
  and_bitwise #(.N(N)) u_and_bitwise (
    .a (a),
    .b (b),
    .y (and_y_p0)
  );

  assign flags_p0 = flags_of(and_y_p0);

  // ---- stage p1: output register bank ----
  // Data is loaded only on accepted ops. This keeps the held value stable,
  // even when a/b float or go X while idle. The reset value zero = 1 matches
  // the reset value result = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      flags_p1  <= '{zero: 1'b1, neg: 1'b0};
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        result_p1 <= and_y_p0;
        flags_p1  <= flags_p0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign result    = result_p1;
  assign zero      = flags_p1.zero;
  assign neg       = flags_p1.neg;

endmodule : alu_and

// File: tb/tb_alu_and.sv
// Self-checking bench for alu_and (N = 64).
// Expected results are pushed to a scoreboard when an op is driven. They are
// popped and compared when the DUT raises out_valid one cycle later.
module tb_alu_and;

  localparam int N = 64;

  typedef struct {
    logic [N-1:0] r;
    logic         z;
    logic         n;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic [N-1:0] result;
  logic         zero;
  logic         neg;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  alu_and #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus at the falling edge.
  // For a valid op, push the expected value, then sample 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic [N-1:0] x, input logic [N-1:0] y);
    exp_t e;
    @(negedge clk);
    in_valid = v;
    a = x;
    b = y;
    if (v) begin
      e.r = '0;
      for (int i = 0; i < N; i++) e.r[i] = x[i] && y[i];
      e.z = (e.r == '0);
      e.n = x[N-1] && y[N-1];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    checks++; if (neg !== 1'b0) begin errors++; $display("FAIL reset_neg: got %b want 0", neg); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [N-1:0] ta[4] = '{64'h0, 64'h1, 64'h0, 64'h1};
    logic [N-1:0] tb[4] = '{64'h0, 64'h0, 64'h1, 64'h1};
    logic [N-1:0] tr[4] = '{64'h0, 64'h0, 64'h0, 64'h1};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ta[i], tb[i]);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b want 1", i, out_valid); end
      e = sb.pop_front();
      checks++; if (result !== e.r || result !== tr[i]) begin errors++; $display("FAIL basic_result[%0d]: got %h want %h", i, result, tr[i]); end
      checks++; if (zero !== e.z) begin errors++; $display("FAIL basic_zero[%0d]: got %b want %b", i, zero, e.z); end
    end
  endtask

  task automatic test_patterns();
    logic [N-1:0] ta[4] = '{64'h1, 64'h3, 64'h9, 64'hF};
    logic [N-1:0] tb[4] = '{64'h5, 64'h3, 64'hB, 64'hF};
    logic [N-1:0] tr[4] = '{64'h1, 64'h3, 64'h9, 64'hF};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ta[i], tb[i]);
      e = sb.pop_front();
      checks++; if (out_valid !== 1'b1 || result !== tr[i] || result !== e.r) begin errors++; $display("FAIL pattern[%0d]: got v=%b %h want v=1 %h", i, out_valid, result, tr[i]); end
      checks++; if (zero !== e.z || neg !== e.n) begin errors++; $display("FAIL pattern_flags[%0d]: got z=%b n=%b want z=%b n=%b", i, zero, neg, e.z, e.n); end
      // Idle a cycle and confirm the value is not shifted by an extra stage.
      drive(1'b0, '0, '0);
      checks++; if (out_valid !== 1'b0 || result !== tr[i]) begin errors++; $display("FAIL pattern_latency[%0d]: got v=%b %h want v=0 %h", i, out_valid, result, tr[i]); end
    end
  endtask

  task automatic test_width();
    exp_t e;
    drive(1'b1, {N{1'b1}}, {N{1'b1}});
    e = sb.pop_front();
    checks++; if (result !== {N{1'b1}} || result !== e.r) begin errors++; $display("FAIL width_ones_result: got %h want all-ones", result); end
    checks++; if (neg !== 1'b1 || zero !== 1'b0) begin errors++; $display("FAIL width_ones_flags: got z=%b n=%b want z=0 n=1", zero, neg); end
    drive(1'b1, {(N/2){2'b10}}, {(N/2){2'b01}});
    e = sb.pop_front();
    checks++; if (result !== '0 || zero !== 1'b1 || neg !== 1'b0 || result !== e.r) begin errors++; $display("FAIL width_alt: got %h z=%b n=%b want 0 z=1 n=0", result, zero, neg); end
    drive(1'b1, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0000);
    e = sb.pop_front();
    checks++; if (result !== 64'h8000_0000_0000_0000 || neg !== 1'b1 || zero !== e.z) begin errors++; $display("FAIL width_msb: got %h n=%b want 8000000000000000 n=1", result, neg); end
  endtask

  task automatic test_valid_gating();
    logic [N-1:0] ta[4] = '{64'h1, 64'h3, 64'h9, 64'hF};
    logic [N-1:0] tb[4] = '{64'h5, 64'h3, 64'hB, 64'hF};
    int vcount = 0;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ta[i], tb[i]);
      if (out_valid === 1'b1) vcount++;
      e = sb.pop_front();
      checks++; if (result !== e.r) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", i, result, e.r); end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 'x, 'x);
      if (out_valid === 1'b1) vcount++;
      checks++; if (out_valid !== 1'b0 || result !== 64'hF || zero !== 1'b0 || neg !== 1'b0) begin errors++; $display("FAIL idle_hold[%0d]: got v=%b %h z=%b n=%b want v=0 f z=0 n=0", i, out_valid, result, zero, neg); end
    end
    checks++; if (vcount != 4) begin errors++; $display("FAIL valid_count: got %0d want 4", vcount); end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    drive(1'b1, {N{1'b1}}, 64'hFFFF_0000_FFFF_0000);
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || result !== e.r) begin errors++; $display("FAIL pre_reset: got v=%b %h want v=1 %h", out_valid, result, e.r); end
    // Assert reset between edges: outputs drop immediately.
    @(negedge clk);
    in_valid = 1'b1;
    a = {N{1'b1}};
    b = {N{1'b1}};
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 || neg !== 1'b0) begin errors++; $display("FAIL async_reset: got v=%b %h z=%b n=%b want v=0 0 z=1 n=0", out_valid, result, zero, neg); end
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || result !== '0) begin errors++; $display("FAIL reset_hold: got v=%b %h want v=0 0", out_valid, result); end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || result !== '0) begin errors++; $display("FAIL dropped_op: got v=%b %h want v=0 0", out_valid, result); end
    drive(1'b1, 64'h3, 64'h3);
    e = sb.pop_front();
    checks++; if (out_valid !== 1'b1 || result !== 64'h3 || result !== e.r || zero !== 1'b0) begin errors++; $display("FAIL post_reset_op: got v=%b %h want v=1 3", out_valid, result); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_width();
    test_valid_gating();
    test_mid_reset();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty: got %0d entries want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_and
